// File: rtl/sqrt_pkg.sv
// Shared types for the isqrt result buffer: widths, entry layout, root checker.
package sqrt_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 4;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [RES_W-1:0] root;
        logic             err;
    } entry_t;

    // 9-bit math so (15+1)^2 = 256 is exact
    function automatic logic root_err(
        input logic [OP_W-1:0]  op,
        input logic [RES_W-1:0] r
    );
        logic [8:0] r9;
        logic [8:0] op9;
        logic [8:0] lo;
        logic [8:0] hi;
        r9  = {5'b0, r};
        op9 = {1'b0, op};
        lo  = r9 * r9;
        hi  = (r9 + 9'd1) * (r9 + 9'd1);
        return !(lo <= op9 && op9 < hi);
    endfunction

endpackage

// File: rtl/sqrt_fifo.sv
// Result FIFO: synchronous write, registered head output, full/empty/count.
module sqrt_fifo
    import sqrt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_next;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_next;
    entry_t          head_q;
    entry_t          head_next;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_next = pop_ok ? rd_ptr + PW'(1) : rd_ptr;
    assign cnt_next = cnt_q + CW'(push_ok) - CW'(pop_ok);

    // head slot being written this cycle must bypass the array
    always_comb begin
        head_next = mem[rd_next];
        if (cnt_next == '0)
            head_next = '0;
        else if (push_ok && wr_ptr == rd_next)
            head_next = din;
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_next;
            cnt_q  <= cnt_next;
            head_q <= head_next;
        end
    end

    assign dout  = head_q;
    assign count = cnt_q;

endmodule

// File: rtl/sqrt_result_buffer.sv
// Pairs isqrt operands with roots and queues them for a consumer.
// Optional root checker enabled by defining SQRT_CHECK_EN.
module sqrt_result_buffer
    import sqrt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    start,
    input  logic [OP_W-1:0]         a,
    input  logic [RES_W-1:0]        sq,
    input  logic                    valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OP_W-1:0]         out_a,
    output logic [RES_W-1:0]        out_sq,
    output logic                    out_err,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ovf,
    output logic                    lost
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]      state_q;
    logic [OP_W-1:0] op_q;
    logic            ovf_q;
    logic            lost_q;
    logic            do_push;
    logic            do_pop;
    logic            full;
    logic            empty;
    logic            chk_err;
    entry_t          din;
    entry_t          head;

    assign do_push = (state_q == S_BUSY) && valid;
    assign do_pop  = out_valid && out_ready;

`ifdef SQRT_CHECK_EN
    assign chk_err = root_err(op_q, sq);
`else
    // constant zero; the stored bit folds away
    assign chk_err = 1'b0;
`endif

    assign din.op   = op_q;
    assign din.root = sq;
    assign din.err  = chk_err;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ovf_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_BUSY;
                        op_q    <= a;
                    end
                end
                S_BUSY: begin
                    if (valid)
                        state_q <= S_IDLE;
                    if (start)
                        lost_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
            if (do_push && full && !do_pop)
                ovf_q <= 1'b1;
        end
    end

    sqrt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (do_push),
        .pop   (do_pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign out_valid = !empty;
    assign out_a     = head.op;
    assign out_sq    = head.root;
    assign out_err   = head.err;
    assign ovf       = ovf_q;
    assign lost      = lost_q;

endmodule
